// File: rtl/fetch_unit_if.sv
//==============================================================================
// Module      : fetch_unit_if
// Description : Memory, decode and control signals of the instruction fetch unit.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        misalign_err;

    modport master (
        output imem_req, imem_addr, ir, ir_pc, ir_valid, misalign_err,
        input  imem_gnt, imem_rvalid, imem_rdata, ir_ready,
               redirect_valid, redirect_pc, halt
    );

    modport slave (
        input  imem_req, imem_addr, ir, ir_pc, ir_valid, misalign_err,
        output imem_gnt, imem_rvalid, imem_rdata, ir_ready,
               redirect_valid, redirect_pc, halt
    );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
//==============================================================================
// Module      : fetch_unit
// Description : Instruction fetch front end with in-order buffer and redirects.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    fetch_unit_if.master      bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]   c_depth_ext = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] c_full      = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    state_t           w_resume;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_resp_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_discard;
    logic [CNT_W-1:0] w_discard_next;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [31:0]      r_data_mem [DEPTH];
    logic [31:0]      r_pc_mem   [DEPTH];
    logic             r_misalign;

    logic             w_credit_ok;
    logic             w_req;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_head_valid;
    logic [31:0]      w_target;

    assign w_target     = {bus.redirect_pc[31:2], 2'b00};
    assign w_head_valid = (r_count != '0);
    assign w_credit_ok  = ({1'b0, r_count} + {1'b0, r_outstanding}) < c_depth_ext;
    // Gated by rst_n so no request is visible while reset is held.
    assign w_req        = rst_n && (r_state == ST_RUN) && !bus.redirect_valid && w_credit_ok;
    assign w_accept     = w_req && bus.imem_gnt;
    assign w_pop        = w_head_valid && bus.ir_ready && !bus.redirect_valid;
    assign w_push       = bus.imem_rvalid && (r_discard == '0) && !bus.redirect_valid;

    // A response arriving in the redirect cycle is dropped and so not counted as stale.
    always_comb begin
        w_discard_next = r_discard;
        if (bus.redirect_valid) begin
            w_discard_next = r_outstanding - {{(CNT_W-1){1'b0}}, bus.imem_rvalid};
        end else if (bus.imem_rvalid && (r_discard != '0)) begin
            w_discard_next = r_discard - CNT_W'(1);
        end
    end

    always_comb begin
        w_resume     = bus.halt ? ST_HALT : ST_RUN;
        w_state_next = r_state;
        if (bus.redirect_valid) begin
            w_state_next = (w_discard_next != '0) ? ST_DRAIN : w_resume;
        end else begin
            case (r_state)
                ST_RUN:   if (bus.halt) w_state_next = ST_HALT;
                ST_HALT:  if (!bus.halt) w_state_next = ST_RUN;
                ST_DRAIN: if (w_discard_next == '0) w_state_next = w_resume;
                default:  w_state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_misalign    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_discard  <= w_discard_next;
            r_misalign <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);

            case ({w_accept, bus.imem_rvalid})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            if (bus.redirect_valid) begin
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage needs no reset; validity is carried entirely by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data_mem[r_wr_ptr] <= bus.imem_rdata;
            r_pc_mem[r_wr_ptr]   <= r_resp_pc;
        end
        if (rst_n && w_push && !w_pop) begin
            assert (r_count != c_full);
        end
    end

    assign bus.imem_req     = w_req;
    assign bus.imem_addr    = r_fetch_pc;
    assign bus.ir_valid     = w_head_valid;
    assign bus.ir           = w_head_valid ? r_data_mem[r_rd_ptr] : NOP_INSN;
    assign bus.ir_pc        = w_head_valid ? r_pc_mem[r_rd_ptr] : 32'h0000_0000;
    assign bus.misalign_err = r_misalign;

endmodule

`default_nettype wire
